// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: IEEE 1149.1 TAP state machine with instruction register,
// bypass register and TDO multiplexer; everything runs on rising TCK.
module jtag_tap_controller #(
    parameter int IR_WIDTH = 4
) (
    input  logic                TCK,
    input  logic                Reset,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                DR_TDO,
    output logic                TDO,
    output logic                TDO_En,
    output logic                Test_Logic_Reset,
    output logic                Run_Test_Idle,
    output logic                Capture_DR,
    output logic                Shift_DR,
    output logic                Update_DR,
    output logic                Capture_IR,
    output logic                Shift_IR,
    output logic                Update_IR,
    output logic [IR_WIDTH-1:0] Instr,
    output logic                Mode
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_t;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_INTEST = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

    state_t                r_state;
    state_t                w_next;
    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   r_instr;
    logic                  r_bypass;
    logic                  w_bypass_sel;

    always_comb begin
        w_next = TLR;
        unique case (r_state)
            TLR:    w_next = TMS ? TLR    : RTI;
            RTI:    w_next = TMS ? SEL_DR : RTI;
            SEL_DR: w_next = TMS ? SEL_IR : CAP_DR;
            CAP_DR: w_next = TMS ? EX1_DR : SH_DR;
            SH_DR:  w_next = TMS ? EX1_DR : SH_DR;
            EX1_DR: w_next = TMS ? UPD_DR : PAU_DR;
            PAU_DR: w_next = TMS ? EX2_DR : PAU_DR;
            EX2_DR: w_next = TMS ? UPD_DR : SH_DR;
            UPD_DR: w_next = TMS ? SEL_DR : RTI;
            SEL_IR: w_next = TMS ? TLR    : CAP_IR;
            CAP_IR: w_next = TMS ? EX1_IR : SH_IR;
            SH_IR:  w_next = TMS ? EX1_IR : SH_IR;
            EX1_IR: w_next = TMS ? UPD_IR : PAU_IR;
            PAU_IR: w_next = TMS ? EX2_IR : PAU_IR;
            EX2_IR: w_next = TMS ? UPD_IR : SH_IR;
            UPD_IR: w_next = TMS ? SEL_DR : RTI;
            default: w_next = TLR;
        endcase
    end

    // Instr is forced to BYPASS on the edge that enters TLR so it is valid on arrival
    always_ff @(posedge TCK) begin
        if (Reset) begin
            r_state  <= TLR;
            r_ir     <= OP_SAMPLE;
            r_instr  <= OP_BYPASS;
            r_bypass <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == CAP_IR)
                r_ir <= OP_SAMPLE;
            else if (r_state == SH_IR)
                r_ir <= {TDI, r_ir[IR_WIDTH-1:1]};
            if (w_next == TLR || r_state == TLR)
                r_instr <= OP_BYPASS;
            else if (r_state == UPD_IR)
                r_instr <= r_ir;
            if (r_state == CAP_DR)
                r_bypass <= 1'b0;
            else if (r_state == SH_DR && w_bypass_sel)
                r_bypass <= TDI;
        end
    end

    assign Instr        = r_instr;
    assign Mode         = (r_instr == OP_EXTEST) || (r_instr == OP_INTEST);
    assign w_bypass_sel = !((r_instr == OP_EXTEST) || (r_instr == OP_SAMPLE) || (r_instr == OP_INTEST));

    assign Test_Logic_Reset = (r_state == TLR);
    assign Run_Test_Idle    = (r_state == RTI);
    assign Capture_DR       = (r_state == CAP_DR);
    assign Shift_DR         = (r_state == SH_DR);
    assign Update_DR        = (r_state == UPD_DR);
    assign Capture_IR       = (r_state == CAP_IR);
    assign Shift_IR         = (r_state == SH_IR);
    assign Update_IR        = (r_state == UPD_IR);

    assign TDO_En = Shift_DR || Shift_IR;
    assign TDO    = Shift_IR ? r_ir[0] : Shift_DR ? (w_bypass_sel ? r_bypass : DR_TDO) : 1'b0;
endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb_jtag_tap_controller: directed TAP walk; expected output vectors are queued
// when each step is driven and compared once the following TCK edge has settled.
module tb_jtag_tap_controller;
    logic       TCK = 1'b0;
    logic       Reset = 1'b0;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       DR_TDO = 1'b0;
    logic       TDO, TDO_En, Test_Logic_Reset, Run_Test_Idle;
    logic       Capture_DR, Shift_DR, Update_DR, Capture_IR, Shift_IR, Update_IR;
    logic [3:0] Instr;
    logic       Mode;
    logic [14:0] obs;

    jtag_tap_controller #(.IR_WIDTH(4)) dut (
        .TCK(TCK), .Reset(Reset), .TMS(TMS), .TDI(TDI), .DR_TDO(DR_TDO),
        .TDO(TDO), .TDO_En(TDO_En), .Test_Logic_Reset(Test_Logic_Reset),
        .Run_Test_Idle(Run_Test_Idle), .Capture_DR(Capture_DR), .Shift_DR(Shift_DR),
        .Update_DR(Update_DR), .Capture_IR(Capture_IR), .Shift_IR(Shift_IR),
        .Update_IR(Update_IR), .Instr(Instr), .Mode(Mode)
    );

    always #5 TCK = ~TCK;

    assign obs = {TDO, TDO_En, Test_Logic_Reset, Run_Test_Idle, Capture_DR, Shift_DR,
                  Update_DR, Capture_IR, Shift_IR, Update_IR, Mode, Instr};

    localparam logic [7:0] I_N = 8'h00, I_TLR = 8'h80, I_RTI = 8'h40, I_CDR = 8'h20,
                           I_SDR = 8'h10, I_UDR = 8'h08, I_CIR = 8'h04, I_SIR = 8'h02,
                           I_UIR = 8'h01;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // TMS paths from TLR to each of the 16 states, applied MSB first
    int         plen[16]  = '{1, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [6:0] pbits[16] = '{7'b1, 7'b0, 7'b01, 7'b010, 7'b0100, 7'b0101, 7'b01010,
                              7'b010101, 7'b01011, 7'b011, 7'b0110, 7'b01100, 7'b01101,
                              7'b011010, 7'b0110101, 7'b011011};
    logic [7:0] pind[16]  = '{I_TLR, I_RTI, I_N, I_CDR, I_SDR, I_N, I_N, I_N, I_UDR,
                              I_N, I_CIR, I_SIR, I_N, I_N, I_N, I_UIR};
    logic       ptdo[16]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    function automatic logic [14:0] mk(input logic [7:0] ind, input logic tdo, input logic [3:0] ins);
        return {tdo, (ind == I_SDR) || (ind == I_SIR), ind, (ins == 4'b0000) || (ins == 4'b0010), ins};
    endfunction

    task automatic step(input logic rst, input logic tms, input logic tdi, input logic dtdo,
                        input logic chk, input string tag, input logic [7:0] ind,
                        input logic tdo, input logic [3:0] ins);
        exp_t e;
        @(negedge TCK);
        Reset = rst; TMS = tms; TDI = tdi; DR_TDO = dtdo;
        if (chk) begin
            e.tag = tag;
            e.v = mk(ind, tdo, ins);
            q.push_back(e);
        end
        @(posedge TCK);
        #1;
        if (chk) begin
            e = q.pop_front();
            checks++;
            assert (obs === e.v) passed++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic c(input logic tms, input logic tdi, input logic dtdo, input string tag,
                     input logic [7:0] ind, input logic tdo, input logic [3:0] ins);
        step(1'b0, tms, tdi, dtdo, 1'b1, tag, ind, tdo, ins);
    endtask

    task automatic u(input logic tms, input logic tdi);
        step(1'b0, tms, tdi, 1'b0, 1'b0, "", I_N, 1'b0, 4'h0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "reset", I_TLR, 0, 4'hF);
        c(0, 0, 0, "rti", I_RTI, 0, 4'hF);
        // capture 0001, shift in 0,1,0,0 -> INTEST
        c(1, 0, 0, "ir_seldr", I_N, 0, 4'hF);
        c(1, 0, 0, "ir_selir", I_N, 0, 4'hF);
        c(0, 0, 0, "capir", I_CIR, 0, 4'hF);
        c(0, 0, 0, "shir0", I_SIR, 1, 4'hF);
        c(0, 0, 0, "shir1", I_SIR, 0, 4'hF);
        c(0, 1, 0, "shir2", I_SIR, 0, 4'hF);
        c(0, 0, 0, "shir3", I_SIR, 0, 4'hF);
        c(1, 0, 0, "ex1ir", I_N, 0, 4'hF);
        c(1, 0, 0, "updir", I_UIR, 0, 4'hF);
        c(0, 0, 0, "intest", I_RTI, 0, 4'h2);
        // load BYPASS, then shift 1,0,1,1 through the bypass bit
        c(1, 0, 0, "b_seldr", I_N, 0, 4'h2);
        c(1, 0, 0, "b_selir", I_N, 0, 4'h2);
        c(0, 0, 0, "b_capir", I_CIR, 0, 4'h2);
        c(0, 1, 0, "b_shir0", I_SIR, 1, 4'h2);
        c(0, 1, 0, "b_shir1", I_SIR, 0, 4'h2);
        c(0, 1, 0, "b_shir2", I_SIR, 0, 4'h2);
        c(0, 1, 0, "b_shir3", I_SIR, 0, 4'h2);
        c(1, 1, 0, "b_ex1ir", I_N, 0, 4'h2);
        c(1, 0, 0, "b_updir", I_UIR, 0, 4'h2);
        c(1, 0, 0, "b_seldr2", I_N, 0, 4'hF);
        c(0, 0, 0, "b_capdr", I_CDR, 0, 4'hF);
        c(0, 0, 1, "byp0", I_SDR, 0, 4'hF);
        c(0, 1, 1, "byp1", I_SDR, 1, 4'hF);
        c(0, 0, 1, "byp2", I_SDR, 0, 4'hF);
        c(0, 1, 0, "byp3", I_SDR, 1, 4'hF);
        c(1, 1, 0, "b_ex1dr", I_N, 0, 4'hF);
        c(1, 0, 0, "b_upddr", I_UDR, 0, 4'hF);
        c(0, 0, 0, "b_rti", I_RTI, 0, 4'hF);
        // load EXTEST, DR_TDO passthrough and pause
        c(1, 0, 0, "e_seldr", I_N, 0, 4'hF);
        c(1, 0, 0, "e_selir", I_N, 0, 4'hF);
        c(0, 0, 0, "e_capir", I_CIR, 0, 4'hF);
        c(0, 0, 0, "e_shir0", I_SIR, 1, 4'hF);
        c(0, 0, 0, "e_shir1", I_SIR, 0, 4'hF);
        c(0, 0, 0, "e_shir2", I_SIR, 0, 4'hF);
        c(0, 0, 0, "e_shir3", I_SIR, 0, 4'hF);
        c(1, 0, 0, "e_ex1ir", I_N, 0, 4'hF);
        c(1, 0, 0, "e_updir", I_UIR, 0, 4'hF);
        c(0, 0, 0, "extest", I_RTI, 0, 4'h0);
        c(1, 0, 0, "e_seldr2", I_N, 0, 4'h0);
        c(0, 0, 0, "e_capdr", I_CDR, 0, 4'h0);
        c(0, 0, 1, "dr0", I_SDR, 1, 4'h0);
        c(0, 0, 0, "dr1", I_SDR, 0, 4'h0);
        c(0, 0, 1, "dr2", I_SDR, 1, 4'h0);
        c(1, 0, 1, "e_ex1dr", I_N, 0, 4'h0);
        c(0, 0, 1, "pause0", I_N, 0, 4'h0);
        c(0, 0, 1, "pause1", I_N, 0, 4'h0);
        c(0, 0, 1, "pause2", I_N, 0, 4'h0);
        c(1, 0, 1, "e_ex2dr", I_N, 0, 4'h0);
        c(0, 0, 1, "dr_resume", I_SDR, 1, 4'h0);
        c(0, 0, 0, "dr_resume2", I_SDR, 0, 4'h0);
        c(1, 0, 0, "e_ex1dr2", I_N, 0, 4'h0);
        c(1, 0, 0, "e_upddr", I_UDR, 0, 4'h0);
        c(1, 0, 0, "t_seldr", I_N, 0, 4'h0);
        c(1, 0, 0, "t_selir", I_N, 0, 4'h0);
        c(1, 0, 0, "t_tlr", I_TLR, 0, 4'hF);
        u(1, 0);
        u(1, 0);
        for (int s = 0; s < 16; s++) begin
            for (int i = plen[s] - 1; i >= 0; i--) begin
                if (i == 0)
                    c(pbits[s][i], 0, 0, $sformatf("arrive%0d", s), pind[s], ptdo[s], 4'hF);
                else
                    u(pbits[s][i], 0);
            end
            for (int k = 0; k < 5; k++) begin
                if (k == 4)
                    c(1, 0, 0, $sformatf("tlr_from%0d", s), I_TLR, 0, 4'hF);
                else
                    u(1, 0);
            end
        end
        // reset coincident with UpdIR holding 0000 must not load Instr
        u(0, 0);
        u(1, 0);
        u(1, 0);
        u(0, 0);
        c(0, 0, 0, "r_shir", I_SIR, 1, 4'hF);
        u(0, 0);
        u(0, 0);
        u(0, 0);
        u(1, 0);
        c(1, 0, 0, "r_updir", I_UIR, 0, 4'hF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "reset_updir", I_TLR, 0, 4'hF);
        c(0, 0, 0, "post_reset_rti", I_RTI, 0, 4'hF);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
